int_to_float32: RTL and testbench

Multi-cycle converter from a parametrised-width signed or unsigned integer to IEEE-754 binary32, with valid/ready handshakes on both sides. The integer mode is selected per transaction. Inputs wider than 24 significant bits are rounded to nearest, ties to even, and an inexact flag is reported. It sits in the floating-point arithmetic library as the general integer-to-float front end feeding the F32 datapath.

---
 rtl/int_to_float32_if.sv | 42 ++++
 rtl/int_to_float32.sv | 162 ++++++++++++++++
 tb/tb_int_to_float32.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/int_to_float32_if.sv
// rtl/int_to_float32_if.sv - Handshake bundle between an integer producer, the converter and the F32 consumer
//
// Ports (signals carried by the bundle):
//   i_data_in_valid / o_data_in_ready  : operand handshake into the converter
//   i_data_in, i_signed                : operand word and its signedness
//   o_data_out, o_inexact              : binary32 result and rounding flag
//   o_data_out_valid / i_data_out_ready: result handshake out of the converter
// The slave modport is the converter; the master modport is its environment.
interface int_to_float32_if #(
    parameter int DATA_IN_WIDTH = 32
);
    logic                     i_data_in_valid;
    logic                     o_data_in_ready;
    logic [DATA_IN_WIDTH-1:0] i_data_in;
    logic                     i_signed;
    logic [31:0]              o_data_out;
    logic                     o_inexact;
    logic                     o_data_out_valid;
    logic                     i_data_out_ready;

    modport master (
        output i_data_in_valid,
        input  o_data_in_ready,
        output i_data_in,
        output i_signed,
        input  o_data_out,
        input  o_inexact,
        input  o_data_out_valid,
        output i_data_out_ready
    );

    modport slave (
        input  i_data_in_valid,
        output o_data_in_ready,
        input  i_data_in,
        input  i_signed,
        output o_data_out,
        output o_inexact,
        output o_data_out_valid,
        input  i_data_out_ready
    );
endinterface

// File: rtl/int_to_float32.sv
// rtl/int_to_float32.sv - Multi-cycle signed/unsigned integer to IEEE-754 binary32 converter
//
// Ports:
//   clk      : clock, all logic on the rising edge
//   reset_n  : synchronous active-low reset; discards any in-flight conversion
//   bus      : int_to_float32_if.slave handshake bundle (operand in, result out)
// One conversion in flight: IDLE -> LOAD -> NORM (L+1 cycles) -> ROUND -> OUT.
// Operands wider than 24 significant bits are rounded to nearest, ties to even.
module int_to_float32 #(
    parameter int DATA_IN_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    int_to_float32_if.slave     bus
);
    localparam int W = DATA_IN_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   data_q, data_d;
    logic           signed_q, signed_d;
    logic           sign_q, sign_d;
    logic [W-1:0]   mag_q, mag_d;
    logic [7:0]     exp_q, exp_d;
    logic           zero_q, zero_d;
    logic [31:0]    out_q, out_d;
    logic           inexact_q, inexact_d;
    logic           valid_q, valid_d;

    // Rounded fraction of the normalised magnitude (hidden bit at mag_q[W-1]).
    logic [22:0]    rnd_frac;
    logic           rnd_carry;
    logic           rnd_inexact;

    generate
        if (W > 24) begin : g_round
            logic [22:0] frac_t;
            logic        guard;
            logic        sticky;
            logic        round_up;

            assign frac_t = mag_q[W-2 -: 23];
            assign guard  = mag_q[W-25];

            if (W > 25) begin : g_sticky
                assign sticky = |mag_q[W-26:0];
            end else begin : g_no_sticky
                assign sticky = 1'b0;
            end

            assign round_up    = guard & (sticky | frac_t[0]);
            // An all-ones fraction rounding up wraps to zero and bumps the exponent.
            assign rnd_carry   = round_up & (&frac_t);
            assign rnd_frac    = frac_t + {22'd0, round_up};
            assign rnd_inexact = guard | sticky;
        end else begin : g_exact
            // Every significant bit fits: left-align below the hidden bit.
            assign rnd_frac    = 23'(mag_q[W-2:0]) << (24 - W);
            assign rnd_carry   = 1'b0;
            assign rnd_inexact = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            signed_q  <= 1'b0;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            exp_q     <= '0;
            zero_q    <= 1'b0;
            out_q     <= '0;
            inexact_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            signed_q  <= signed_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            zero_q    <= zero_d;
            out_q     <= out_d;
            inexact_q <= inexact_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        signed_d  = signed_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        zero_d    = zero_q;
        out_d     = out_q;
        inexact_d = inexact_q;
        valid_d   = valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_data_in_valid) begin
                    data_d   = bus.i_data_in;
                    signed_d = bus.i_signed;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                sign_d = signed_q & data_q[W-1];
                // Negating the most negative value wraps to 2^(W-1), which is
                // exactly its magnitude when read as unsigned.
                mag_d  = sign_d ? -data_q : data_q;
                exp_d  = 8'(W - 1);
                zero_d = (mag_d == '0);
                state_d = zero_d ? S_ROUND : S_NORM;
            end
            S_NORM: begin
                if (!mag_q[W-1]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 8'd1;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (zero_q) begin
                    out_d     = 32'h0000_0000;
                    inexact_d = 1'b0;
                end else begin
                    out_d     = {sign_q, exp_q + 8'd127 + {7'd0, rnd_carry}, rnd_frac};
                    inexact_d = rnd_inexact;
                end
                valid_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.i_data_out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.o_data_in_ready  = (state_q == S_IDLE);
    assign bus.o_data_out       = out_q;
    assign bus.o_inexact        = inexact_q;
    assign bus.o_data_out_valid = valid_q;

endmodule

// File: tb/tb_int_to_float32.sv
// tb/tb_int_to_float32.sv - Self-checking bench for int_to_float32 (W=32 and W=8 instances)
module tb_int_to_float32;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        sel8 = 1'b0;
    logic        drv_valid = 1'b0;
    logic [31:0] drv_data = '0;
    logic        drv_signed = 1'b0;
    logic        drv_ready = 1'b0;

    int_to_float32_if #(.DATA_IN_WIDTH(32)) if32 ();
    int_to_float32_if #(.DATA_IN_WIDTH(8))  if8 ();

    assign if32.i_data_in_valid  = drv_valid & ~sel8;
    assign if32.i_data_in        = drv_data;
    assign if32.i_signed         = drv_signed;
    assign if32.i_data_out_ready = drv_ready & ~sel8;
    assign if8.i_data_in_valid   = drv_valid & sel8;
    assign if8.i_data_in         = drv_data[7:0];
    assign if8.i_signed          = drv_signed;
    assign if8.i_data_out_ready  = drv_ready & sel8;

    int_to_float32 #(.DATA_IN_WIDTH(32)) u_dut32 (.clk(clk), .reset_n(reset_n), .bus(if32));
    int_to_float32 #(.DATA_IN_WIDTH(8))  u_dut8  (.clk(clk), .reset_n(reset_n), .bus(if8));

    logic        m_valid, m_ready, m_inex;
    logic [31:0] m_data;
    assign m_valid = sel8 ? if8.o_data_out_valid : if32.o_data_out_valid;
    assign m_ready = sel8 ? if8.o_data_in_ready  : if32.o_data_in_ready;
    assign m_inex  = sel8 ? if8.o_inexact        : if32.o_inexact;
    assign m_data  = sel8 ? if8.o_data_out       : if32.o_data_out;

    typedef struct {
        bit          w8;
        bit          sgn;
        logic [31:0] din;
        logic [31:0] ef;
        bit          ei;
        int          el;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: value-level rounding from the exact integer, no bit-serial normalisation.
    function automatic void ref_conv(input int w, input bit sgn, input logic [31:0] din,
                                     output logic [31:0] f, output bit inex, output int lat);
        longint u, v, a, q, rem, half;
        int e, sh;
        bit s;
        u = longint'({32'd0, din}) & ((64'sd1 << w) - 1);
        if (sgn && u >= (64'sd1 << (w - 1))) v = u - (64'sd1 << w);
        else v = u;
        s = (v < 0);
        a = s ? -v : v;
        if (a == 0) begin
            f = 32'd0; inex = 1'b0; lat = 2;
            return;
        end
        e = 0;
        while ((a >> (e + 1)) != 0) e++;
        lat = (w - 1 - e) + 3;
        if (e <= 23) begin
            q = a << (23 - e);
            inex = 1'b0;
        end else begin
            sh = e - 23;
            q = a >> sh;
            rem = a - (q << sh);
            half = 64'sd1 << (sh - 1);
            inex = (rem != 0);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'sd1 << 24)) begin
                q = q >> 1;
                e++;
            end
        end
        f = {s, 8'(e + 127), q[22:0]};
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!m_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " in_ready"}, 32'(m_ready), 32'd1);
    endtask

    task automatic send(input bit w8, input bit sgn, input logic [31:0] din, input string tag);
        sel8 = w8;
        drv_data = din;
        drv_signed = sgn;
        wait_ready(tag);
        drv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!m_valid && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic convert(input bit w8, input bit sgn, input logic [31:0] din,
                           input logic [31:0] ef, input bit ei, input int el, input string tag);
        int n;
        send(w8, sgn, din, tag);
        wait_valid(n);
        chk({tag, " valid"}, 32'(m_valid), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'(el));
        chk({tag, " data"}, m_data, ef);
        chk({tag, " inexact"}, 32'(m_inex), 32'(ei));
        drv_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_ready = 1'b0;
        chk({tag, " valid_after_hs"}, 32'(m_valid), 32'd0);
        chk({tag, " ready_after_hs"}, 32'(m_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ef, din, held;
        bit ei, sgn, w8;
        int el, n;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 34};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 2};
        vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1, 3};
        vecs[3] = '{1'b0, 1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b1, 10};
        vecs[4] = '{1'b0, 1'b0, 32'h0100_0003, 32'h4B80_0002, 1'b1, 10};
        vecs[5] = '{1'b0, 1'b1, 32'h8000_0000, 32'hCF00_0000, 1'b0, 3};
        vecs[6] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 34};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_00FF, 32'h437F_0000, 1'b0, 3};
        vecs[8] = '{1'b1, 1'b1, 32'h0000_0080, 32'hC300_0000, 1'b0, 3};
        vecs[9] = '{1'b1, 1'b1, 32'h0000_007F, 32'h42FE_0000, 1'b0, 4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst32 valid", 32'(if32.o_data_out_valid), 32'd0);
        chk("rst32 data", if32.o_data_out, 32'd0);
        chk("rst32 inexact", 32'(if32.o_inexact), 32'd0);
        chk("rst32 ready", 32'(if32.o_data_in_ready), 32'd1);
        chk("rst8 valid", 32'(if8.o_data_out_valid), 32'd0);
        chk("rst8 ready", 32'(if8.o_data_in_ready), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].w8, vecs[i].sgn, vecs[i].din, vecs[i].ef, vecs[i].ei,
                    vecs[i].el, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            w8 = i[0];
            sgn = 1'($urandom_range(0, 1));
            din = $urandom >> $urandom_range(0, 31);
            if (i % 13 == 5) din = 32'd0;
            if (w8) din = din & 32'h0000_00FF;
            ref_conv(w8 ? 8 : 32, sgn, din, ef, ei, el);
            convert(w8, sgn, din, ef, ei, el, $sformatf("rand%0d", i));
        end

        send(1'b0, 1'b0, 32'h0000_0005, "bp");
        wait_valid(n);
        chk("bp valid", 32'(m_valid), 32'd1);
        chk("bp data", m_data, 32'h40A0_0000);
        held = m_data;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                drv_valid = 1'b1;
                drv_data = 32'hDEAD_BEEF;
            end
            @(posedge clk);
            @(negedge clk);
            drv_valid = 1'b0;
            chk($sformatf("bp hold%0d valid", k), 32'(m_valid), 32'd1);
            chk($sformatf("bp hold%0d data", k), m_data, held);
            chk($sformatf("bp hold%0d in_ready", k), 32'(m_ready), 32'd0);
        end
        drv_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_ready = 1'b0;
        chk("bp valid_after_hs", 32'(m_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp ignored%0d valid", k), 32'(m_valid), 32'd0);
            chk($sformatf("bp ignored%0d ready", k), 32'(m_ready), 32'd1);
        end
        convert(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1, 3, "bp_next");

        send(1'b0, 1'b0, 32'h0000_0001, "rstmid");
        repeat (4) @(negedge clk);
        chk("rstmid busy", 32'(m_ready), 32'd0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rstmid valid", 32'(m_valid), 32'd0);
        chk("rstmid data", m_data, 32'd0);
        chk("rstmid inexact", 32'(m_inex), 32'd0);
        chk("rstmid ready", 32'(m_ready), 32'd1);
        convert(1'b0, 1'b0, 32'h0100_0003, 32'h4B80_0002, 1'b1, 10, "rst_next");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
